digseg_scan_ctrl: RTL and testbench
===================================

Name: digseg_scan_ctrl

Overview:
Bus-slave controller that owns a bank of multiplexed 7-segment digits. It holds a 32-bit display value (one hex nibble per digit) and a control register written over the FPGA bus. It time-multiplexes the digits with a prescaled scan counter, feeding one nibble at a time through a hex-to-segment decoder. It sits on the peripheral bus beside the other fpga/bus drivers and drives the board's segment and anode pins.

Parameters:
NUM_DIGITS, 8, number of scanned digits (legal 1..8)
PRESCALE, 50000, clk cycles each digit stays lit (legal >= 2)
CNT_W, 16, prescaler counter width; must satisfy 2^CNT_W >= PRESCALE

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
cyc_i  in  1  bus cycle valid
stb_i  in  1  bus strobe
we_i  in  1  1 = write, 0 = read
addr_i  in  2  word index into register map
data_i  in  32  write data
data_o  out  32  read data, valid while ack_o = 1
ack_o  out  1  single-cycle transfer acknowledge
seg_o  out  7  segments {a,b,c,d,e,f,g}, 1 = lit
an_o  out  NUM_DIGITS  digit select, active-low, one-hot-low
idx_o  out  3  current scan digit index (debug)

Behaviour:
- Reset (rst = 0, async): DATA = 0; CTRL.en = 1; CTRL.mask = 0xFF; cnt = 0; idx = 0; ack_o = 0; data_o = 0; seg_o = 0; an_o = all ones.
- Register map (word index):
  - 0 DATA, rw; nibble k shown on digit k. Bits above 4*NUM_DIGITS are stored and read back.
  - 1 CTRL, rw; bit0 = en, bits[15:8] = per-digit mask. Other bits read 0.
  - 2 STATUS, ro; bits[2:0] = idx, bits[CNT_W+15:16] = cnt. Writes ignored.
  - 3 reserved; reads 0, writes ignored.
- Bus handshake:
  - A request is accepted when cyc_i & stb_i & !ack_o. ack_o = 1 the following cycle for exactly one cycle.
  - A request still held after ack is re-accepted one cycle later, so back-to-back transfers take 2 cycles each.
  - A write updates its register on the accept edge. data_o is registered on the accept edge, is valid with ack_o, and returns 0 otherwise.
  - Dropping stb_i while ack_o is pending does not cancel ack_o.
- Scan:
  - cnt increments every clk. At cnt == PRESCALE-1, cnt goes to 0 and idx advances. idx wraps from NUM_DIGITS-1 to 0.
  - The scan runs whether or not en = 1, so a full frame takes NUM_DIGITS*PRESCALE cycles.
- Output (registered, computed from next-state idx so seg_o and an_o switch on the same edge):
  - lit = en & mask[idx_next].
  - If lit: an_o = ~(1 << idx_next) and seg_o = decode(DATA nibble idx_next).
  - Otherwise: an_o = all ones and seg_o = 0.
  - Decode uses the standard hex table, e.g. 0 = 1111110, 1 = 0110000, 8 = 1111111, F = 1000111.
- Simultaneous write to DATA or CTRL and digit advance: outputs computed that edge use the old register values. The new values appear no later than the next edge; cnt and idx are unaffected.
- Reset asserted mid-transfer: ack_o drops immediately. The transfer is lost and the master must retry.
- No ghosting: an_o and seg_o change on the same clock edge. an_o never has more than one bit low.

Decomposition:
- Shared defines (existing defines.v): DigSegAddrBus (3:0) and DigSegDataBus (6:0). Add register-index constants DigSegRegData = 2'd0, DigSegRegCtrl = 2'd1, DigSegRegStat = 2'd2, and CTRL field positions.
- Sub-module: digseg_decode, a combinational nibble-to-segment decoder with ce tied high. Blanking is handled in this controller.

Test Plan:
- Reset: hold rst = 0 for 3 cycles, release -> an_o = 8'hFF, seg_o = 0 on the release edge. Then digit 0 lights with seg_o = 1111110 and an_o = 8'hFE within one cycle.
- Write/readback (PRESCALE = 4): write DATA = 32'h89ABCDEF -> ack_o pulses 1 cycle after stb. Read addr 0 -> data_o = 32'h89ABCDEF with ack_o. Read addr 3 -> 0.
- Scan order (PRESCALE = 4): after DATA write, idx steps 0..7 every 4 cycles, wrapping to 0 after 32 cycles. At idx 0, seg_o = 1000111 (F) and an_o = 8'hFE. At idx 7, seg_o = 1111111 (8) and an_o = 8'h7F.
- Masking: write CTRL = 32'h0000_0501 -> only digits 0 and 2 ever drive an_o low. Write CTRL.en = 0 -> an_o = 8'hFF and seg_o = 0 while idx keeps advancing.
- Simultaneous event: issue a DATA write whose accept edge coincides with cnt = PRESCALE-1 -> the new digit shows the old nibble on that edge and the new nibble on the following edge. an_o never has two bits low.
- Reset mid-operation: assert rst during a pending ack and mid-scan -> ack_o, cnt and idx clear immediately. DATA returns to 0 and the scan restarts at digit 0.

Source files
------------

// File: rtl/digseg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// bus widths, register indices and CTRL field positions.
package digseg_scan_ctrl_pkg;

   localparam int DIG_SEG_ADDR_W = 4;
   localparam int DIG_SEG_DATA_W = 7;

   typedef logic [DIG_SEG_ADDR_W-1:0] dig_seg_addr_t;
   typedef logic [DIG_SEG_DATA_W-1:0] dig_seg_data_t;

   localparam logic [1:0] DigSegRegData = 2'd0;
   localparam logic [1:0] DigSegRegCtrl = 2'd1;
   localparam logic [1:0] DigSegRegStat = 2'd2;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MASK_LSB = 8;
   localparam int CTRL_MASK_W   = 8;
   localparam int STAT_CNT_LSB  = 16;

endpackage

// File: rtl/digseg_scan_ctrl_if.sv
// Peripheral-bus signal bundle shared by the bus master and the scan controller.
interface digseg_scan_ctrl_if;

   logic        cyc_i;
   logic        stb_i;
   logic        we_i;
   logic [1:0]  addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        ack_o;

   modport master (
      output cyc_i, stb_i, we_i, addr_i, data_i,
      input  data_o, ack_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, addr_i, data_i,
      output data_o, ack_o
   );

endinterface

// File: rtl/digseg_scan_ctrl_decode.sv
// Combinational hex nibble to {a,b,c,d,e,f,g} segment decoder, 1 = lit.
module digseg_decode
   import digseg_scan_ctrl_pkg::*;
(
   input  logic          ce_i,
   input  logic [3:0]    nib_i,
   output dig_seg_data_t seg_o
);

   // hex lookup, dark when not enabled
   always_comb begin
      seg_o = 7'b0000000;
      if (ce_i) begin
         case (nib_i)
            4'h0:    seg_o = 7'b1111110;
            4'h1:    seg_o = 7'b0110000;
            4'h2:    seg_o = 7'b1101101;
            4'h3:    seg_o = 7'b1111001;
            4'h4:    seg_o = 7'b0110011;
            4'h5:    seg_o = 7'b1011011;
            4'h6:    seg_o = 7'b1011111;
            4'h7:    seg_o = 7'b1110000;
            4'h8:    seg_o = 7'b1111111;
            4'h9:    seg_o = 7'b1111011;
            4'hA:    seg_o = 7'b1110111;
            4'hB:    seg_o = 7'b0011111;
            4'hC:    seg_o = 7'b1001110;
            4'hD:    seg_o = 7'b0111101;
            4'hE:    seg_o = 7'b1001111;
            4'hF:    seg_o = 7'b1000111;
            default: seg_o = 7'b0000000;
         endcase
      end else begin
         seg_o = 7'b0000000;
      end
   end

endmodule

// File: rtl/digseg_scan_ctrl.sv
// Bus-slave 7-segment scan controller: DATA/CTRL/STATUS registers, prescaled
// digit scan and registered, ghost-free segment/anode outputs.
module digseg_scan_ctrl
   import digseg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS = 8,
   parameter int PRESCALE   = 50000,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   digseg_scan_ctrl_if.slave     bus,
   output dig_seg_data_t         seg_o,
   output logic [NUM_DIGITS-1:0] an_o,
   output logic [2:0]            idx_o
);

   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [2:0]             idx_q, idx_d;
   logic [31:0]            data_q, data_d;
   logic                   en_q, en_d;
   logic [CTRL_MASK_W-1:0] mask_q, mask_d;
   logic                   ack_q, ack_d;
   logic [31:0]            rdata_q, rdata_d;
   dig_seg_data_t          seg_q, seg_d;
   logic [NUM_DIGITS-1:0]  an_q, an_d;

   logic                   accept_s;
   logic                   wrap_s;
   logic                   lit_s;
   logic [3:0]             nib_s;
   dig_seg_data_t          dec_s;
   logic [31:0]            rd_mux_s;

   // prescaler and digit index next state
   always_comb begin
      wrap_s = (cnt_q == CNT_W'(PRESCALE - 1));
      cnt_d  = cnt_q + CNT_W'(1);
      idx_d  = idx_q;
      if (wrap_s) begin
         cnt_d = '0;
         if (idx_q == 3'(NUM_DIGITS - 1)) begin
            idx_d = 3'd0;
         end else begin
            idx_d = idx_q + 3'd1;
         end
      end else begin
         idx_d = idx_q;
      end
   end

   // bus accept, register writes and read mux
   always_comb begin
      accept_s = bus.cyc_i & bus.stb_i & ~ack_q;
      data_d   = data_q;
      en_d     = en_q;
      mask_d   = mask_q;
      rd_mux_s = 32'h0000_0000;
      case (bus.addr_i)
         DigSegRegData: rd_mux_s = data_q;
         DigSegRegCtrl: begin
            rd_mux_s[CTRL_EN_BIT]                  = en_q;
            rd_mux_s[CTRL_MASK_LSB +: CTRL_MASK_W] = mask_q;
         end
         DigSegRegStat: begin
            rd_mux_s[2:0]                  = idx_q;
            rd_mux_s[STAT_CNT_LSB +: CNT_W] = cnt_q;
         end
         default:       rd_mux_s = 32'h0000_0000;
      endcase
      ack_d   = accept_s;
      rdata_d = 32'h0000_0000;
      if (accept_s) begin
         if (bus.we_i) begin
            case (bus.addr_i)
               DigSegRegData: data_d = bus.data_i;
               DigSegRegCtrl: begin
                  en_d   = bus.data_i[CTRL_EN_BIT];
                  mask_d = bus.data_i[CTRL_MASK_LSB +: CTRL_MASK_W];
               end
               default: begin
                  data_d = data_q;
               end
            endcase
         end else begin
            rdata_d = rd_mux_s;
         end
      end else begin
         rdata_d = 32'h0000_0000;
      end
   end

   // Outputs follow the next index but the current (pre-write) register contents,
   // so a write landing on a digit advance shows up one edge later.
   always_comb begin
      lit_s = en_q & mask_q[idx_d];
      nib_s = data_q[{idx_d, 2'b00} +: 4];
      if (lit_s) begin
         an_d  = ~(NUM_DIGITS'(1) << idx_d);
         seg_d = dec_s;
      end else begin
         an_d  = '1;
         seg_d = 7'b0000000;
      end
   end

   digseg_decode u_decode (
      .ce_i  (1'b1),
      .nib_i (nib_s),
      .seg_o (dec_s)
   );

   // state and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         data_q  <= 32'h0000_0000;
         en_q    <= 1'b1;
         mask_q  <= 8'hFF;
         ack_q   <= 1'b0;
         rdata_q <= 32'h0000_0000;
         seg_q   <= 7'b0000000;
         an_q    <= '1;
      end else begin
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         en_q    <= en_d;
         mask_q  <= mask_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         seg_q   <= seg_d;
         an_q    <= an_d;
      end
   end

   assign bus.ack_o  = ack_q;
   assign bus.data_o = rdata_q;
   assign seg_o      = seg_q;
   assign an_o       = an_q;
   assign idx_o      = idx_q;

endmodule

// File: tb/tb_digseg_scan_ctrl.sv
// Self-checking bench for digseg_scan_ctrl: table-driven bus transfers, directed
// scan/mask/collision/reset sequences and random traffic against a time-based model.
module tb_digseg_scan_ctrl;

   localparam int ND = 8;
   localparam int P  = 4;
   localparam int CW = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg;
   logic [7:0] an;
   logic [2:0] idx;

   always #5 clk = ~clk;

   digseg_scan_ctrl_if bus_if ();

   digseg_scan_ctrl #(.NUM_DIGITS(ND), .PRESCALE(P), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst   (rst),
      .bus   (bus_if.slave),
      .seg_o (seg),
      .an_o  (an),
      .idx_o (idx)
   );

   int vectors     = 0;
   int miscompares = 0;

   // model: t = clock edges since reset release; cnt and idx derive from it
   int          t;
   logic [31:0] m_data;
   logic        m_en;
   logic [7:0]  m_mask;
   logic        m_ack;
   logic [6:0]  hex_tab [16];

   typedef struct {
      logic        we;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;
   vec_t tbl [10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s actual=%h required=%h (t=%0d)", nm, act, exp, t);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [1:0] a);
      logic [31:0] v;
      case (a)
         2'd0:    v = m_data;
         2'd1:    v = {16'h0000, m_mask, 7'h00, m_en};
         2'd2:    v = (32'(t % P) << 16) | 32'((t / P) % ND);
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   task automatic model_reset();
      t      = 0;
      m_data = 32'h0;
      m_en   = 1'b1;
      m_mask = 8'hFF;
      m_ack  = 1'b0;
   endtask

   // one clock edge: predict, advance model, then compare after the edge
   task automatic tick();
      logic        acc, acc_we;
      int          tn, di;
      logic [6:0]  e_seg;
      logic [7:0]  e_an;
      logic [31:0] e_rd;
      acc    = bus_if.cyc_i & bus_if.stb_i & ~m_ack;
      acc_we = bus_if.we_i;
      tn     = t + 1;
      di     = (tn / P) % ND;
      if (m_en && m_mask[di]) begin
         e_an  = ~(8'd1 << di);
         e_seg = hex_tab[m_data[di*4 +: 4]];
      end else begin
         e_an  = 8'hFF;
         e_seg = 7'b0;
      end
      e_rd = (acc && !acc_we) ? m_read(bus_if.addr_i) : 32'h0;
      if (acc && acc_we) begin
         if (bus_if.addr_i == 2'd0) m_data = bus_if.data_i;
         if (bus_if.addr_i == 2'd1) begin
            m_en   = bus_if.data_i[0];
            m_mask = bus_if.data_i[15:8];
         end
      end
      m_ack = acc;
      t     = tn;
      @(posedge clk);
      #1;
      chk("seg", 32'(seg), 32'(e_seg));
      chk("an", 32'(an), 32'(e_an));
      chk("idx", 32'(idx), 32'((t / P) % ND));
      chk("ack", 32'(bus_if.ack_o), 32'(acc));
      chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
      if (!(acc && acc_we)) chk("data_o", bus_if.data_o, e_rd);
   endtask

   task automatic drive(input logic c, input logic s, input logic w, input logic [1:0] a,
                        input logic [31:0] d);
      bus_if.cyc_i  = c;
      bus_if.stb_i  = s;
      bus_if.we_i   = w;
      bus_if.addr_i = a;
      bus_if.data_i = d;
   endtask

   task automatic xfer(input logic w, input logic [1:0] a, input logic [31:0] d);
      drive(1'b1, 1'b1, w, a, d);
      tick();
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      tick();
   endtask

   initial begin
      logic seen0, seen7;
      hex_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                  7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                  7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
      tbl[0] = '{1'b1, 2'd0, 32'h89AB_CDEF, 32'h0};
      tbl[1] = '{1'b0, 2'd0, 32'h0,         32'h89AB_CDEF};
      tbl[2] = '{1'b0, 2'd3, 32'h0,         32'h0};
      tbl[3] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0};
      tbl[4] = '{1'b0, 2'd3, 32'h0,         32'h0};
      tbl[5] = '{1'b1, 2'd1, 32'hFFFF_FF01, 32'h0};
      tbl[6] = '{1'b0, 2'd1, 32'h0,         32'h0000_FF01};
      tbl[7] = '{1'b1, 2'd2, 32'h1234_5678, 32'h0};
      tbl[8] = '{1'b0, 2'd0, 32'h0,         32'h89AB_CDEF};
      tbl[9] = '{1'b1, 2'd1, 32'h0000_FF01, 32'h0};

      // reset held for three edges
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_an", 32'(an), 32'h0000_00FF);
      chk("rst_seg", 32'(seg), 32'h0);
      chk("rst_ack", 32'(bus_if.ack_o), 32'h0);
      chk("rst_idx", 32'(idx), 32'h0);
      rst = 1'b1;
      tick();
      chk("rst_digit0_seg", 32'(seg), 32'(7'b1111110));
      chk("rst_digit0_an", 32'(an), 32'h0000_00FE);

      // table-driven transfers
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, tbl[i].we, tbl[i].addr, tbl[i].wdata);
         tick();
         chk("tbl_ack", 32'(bus_if.ack_o), 32'd1);
         if (!tbl[i].we) chk("tbl_rdata", bus_if.data_o, tbl[i].exp_rd);
         drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
         tick();
         chk("tbl_ack_low", 32'(bus_if.ack_o), 32'd0);
      end

      // scan order over more than one frame
      seen0 = 1'b0;
      seen7 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (idx == 3'd0 && !seen0) begin
            seen0 = 1'b1;
            chk("scan0_seg", 32'(seg), 32'(7'b1000111));
            chk("scan0_an", 32'(an), 32'h0000_00FE);
         end
         if (idx == 3'd7 && !seen7) begin
            seen7 = 1'b1;
            chk("scan7_seg", 32'(seg), 32'(7'b1111111));
            chk("scan7_an", 32'(an), 32'h0000_007F);
         end
      end
      chk("scan_seen_0_7", 32'({seen0, seen7}), 32'd3);

      // masking: only digits 0 and 2
      xfer(1'b1, 2'd1, 32'h0000_0501);
      for (int i = 0; i < 40; i++) begin
         tick();
         chk("mask_an", 32'(an == 8'hFE || an == 8'hFB || an == 8'hFF), 32'd1);
      end
      xfer(1'b1, 2'd1, 32'h0000_FF00);
      for (int i = 0; i < 16; i++) begin
         tick();
         chk("dis_an", 32'(an), 32'h0000_00FF);
         chk("dis_seg", 32'(seg), 32'h0);
      end

      // write accepted on the digit-advance edge
      xfer(1'b1, 2'd1, 32'h0000_FF01);
      xfer(1'b1, 2'd0, 32'h0000_0000);
      for (int i = 0; i < 2 * P && (t % P) != P - 1; i++) tick();
      chk("coll_align", 32'(t % P), 32'(P - 1));
      drive(1'b1, 1'b1, 1'b1, 2'd0, 32'h1111_1111);
      tick();
      chk("coll_old_nibble", 32'(seg), 32'(7'b1111110));
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      tick();
      chk("coll_new_nibble", 32'(seg), 32'(7'b0110000));

      // random traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), $urandom);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      tick();

      // reset during a pending ack, mid-scan
      xfer(1'b1, 2'd1, 32'h0000_FF01);
      tick();
      drive(1'b1, 1'b1, 1'b1, 2'd0, 32'hDEAD_BEEF);
      tick();
      chk("pre_rst_ack", 32'(bus_if.ack_o), 32'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_rst_ack", 32'(bus_if.ack_o), 32'd0);
      chk("mid_rst_idx", 32'(idx), 32'd0);
      chk("mid_rst_an", 32'(an), 32'h0000_00FF);
      chk("mid_rst_seg", 32'(seg), 32'h0);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      model_reset();
      tick();
      chk("post_rst_seg", 32'(seg), 32'(7'b1111110));
      chk("post_rst_an", 32'(an), 32'h0000_00FE);
      drive(1'b1, 1'b1, 1'b0, 2'd0, 32'h0);
      tick();
      chk("post_rst_data", bus_if.data_o, 32'h0);
      drive(1'b1, 1'b1, 1'b0, 2'd2, 32'h0);
      tick();
      tick();
      chk("post_rst_status", bus_if.data_o, 32'h0003_0000);
      drive(1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
